// File: rtl/write_pointer_full.sv
// Write-domain pointer/full logic of an asynchronous FIFO: binary and Gray write
// pointers, write strobe, full / almost-full flags and fill level. Optional `WPTR_OVERFLOW_EN.
module write_pointer_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wr_clk,
    input  logic                wrst,
    input  logic                wr_en,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wr_inc,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wr_level,
    output logic                wr_overflow
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic [PW-1:0] rq2_bin_s;

    // Next pointers, full compare and pessimistic level from the synced read pointer
    always_comb begin
        wr_inc    = wr_en & ~full_q;
        wbin_d    = wbin_q + {{ADDRSIZE{1'b0}}, wr_inc};
        wgray_d   = bin2gray(wbin_d);
        rq2_bin_s = gray2bin(wq2_rptr);
        level_d   = wbin_d - rq2_bin_s;
        afull_d   = (level_d >= THRESH);
        // Full when the pointers differ only in the wrap bit, which in Gray flips the top two bits
        full_d    = (wgray_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    end

    // Pointer and flag registers
    always_ff @(posedge wr_clk or posedge wrst) begin
        if (wrst) begin
            wbin_q  <= {PW{1'b0}};
            wgray_q <= {PW{1'b0}};
            level_q <= {PW{1'b0}};
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    assign wr_addr      = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wgray_q;
    assign wfull        = full_q;
    assign walmost_full = afull_q;
    assign wr_level     = level_q;

`ifdef WPTR_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // A dropped request sets the sticky error; only reset clears it
    always_comb begin
        ovf_d = ovf_q | (wr_en & full_q);
    end

    // Overflow flag register
    always_ff @(posedge wr_clk or posedge wrst) begin
        if (wrst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign wr_overflow = ovf_q;
`else
    assign wr_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_full.sv
// Self-checking bench for write_pointer_full: directed scenarios plus random traffic
// against an integer-count model of the FIFO occupancy.
module tb_write_pointer_full;

    logic       wr_clk;
    logic       wrst;
    logic       wr_en;
    logic [4:0] wq2_rptr;
    logic       wr_inc;
    logic [3:0] wr_addr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wr_level;
    logic       wr_overflow;

    int total = 0;
    int bad   = 0;

    // model: total items ever written / read (unbounded integers)
    int wcount = 0;
    int rcount = 0;
    bit exp_full = 1'b0;
    bit exp_ovf  = 1'b0;

    write_pointer_full #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
        .wr_clk       (wr_clk),
        .wrst         (wrst),
        .wr_en        (wr_en),
        .wq2_rptr     (wq2_rptr),
        .wr_inc       (wr_inc),
        .wr_addr      (wr_addr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wr_level     (wr_level),
        .wr_overflow  (wr_overflow)
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = 5'(v % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
        chk("wptr", wptr, gray(wcount));
        chk("wfull", wfull, exp_full);
        chk("wr_level", wr_level, wcount - rcount);
        chk("walmost_full", walmost_full, (wcount - rcount) >= 12);
        chk("wr_overflow", wr_overflow, exp_ovf);
    endtask

    // one write-clock cycle; new_rc is the read count visible through the synchroniser
    task automatic cycle(input bit en, input int new_rc);
        bit         exp_inc;
        logic [4:0] prev;
        rcount   = new_rc;
        wr_en    = en;
        wq2_rptr = gray(rcount);
        #1;
        exp_inc = en && !exp_full;
        chk("wr_inc", wr_inc, exp_inc);
        chk("wr_addr", wr_addr, wcount % 16);
        prev = wptr;
        @(posedge wr_clk);
`ifdef WPTR_OVERFLOW_EN
        if (en && exp_full) exp_ovf = 1'b1;
`endif
        if (exp_inc) wcount++;
        exp_full = (wcount - rcount) == 16;
        #1;
        chk_regs();
        if (exp_inc) chk("gray_one_bit", $countones(prev ^ wptr), 1);
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        #1;
        chk("rst_wptr", wptr, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_afull", walmost_full, 0);
        chk("rst_level", wr_level, 0);
        chk("rst_ovf", wr_overflow, 0);
        wcount = 0; rcount = 0; exp_full = 1'b0; exp_ovf = 1'b0;
        wr_en = 1'b0; wq2_rptr = 5'b00000;
        @(posedge wr_clk);
        #1;
        wrst = 1'b0;
    endtask

    initial begin
        wrst = 1'b1; wr_en = 1'b0; wq2_rptr = 5'b00000;
        #2;
        do_reset();

        // almost-full threshold, then fill
        for (int i = 0; i < 11; i++) cycle(1'b1, 0);
        chk("afull_at_11", walmost_full, 1'b0);
        cycle(1'b1, 0);
        chk("afull_at_12", walmost_full, 1'b1);
        chk("level_at_12", wr_level, 5'd12);
        for (int i = 0; i < 4; i++) cycle(1'b1, 0);
        chk("fill_wptr", wptr, 5'b11000);
        chk("fill_wfull", wfull, 1'b1);
        chk("fill_level", wr_level, 5'd16);
        chk("fill_addr", wr_addr, 4'd0);

        // writes while full are dropped
        for (int i = 0; i < 3; i++) cycle(1'b1, 0);
        chk("ovf_wptr", wptr, 5'b11000);
`ifdef WPTR_OVERFLOW_EN
        chk("ovf_flag", wr_overflow, 1'b1);
`else
        chk("ovf_flag", wr_overflow, 1'b0);
`endif

        // drain through the synced read pointer
        cycle(1'b0, 4);
        chk("drain_full", wfull, 1'b0);
        chk("drain_level12", wr_level, 5'd12);
        chk("drain_afull", walmost_full, 1'b1);
        cycle(1'b0, 5);
        chk("drain_level11", wr_level, 5'd11);
        chk("drain_afull_off", walmost_full, 1'b0);

        // asynchronous reset mid-stream
        cycle(1'b1, 5);
        cycle(1'b1, 6);
        do_reset();

        // wrap with constant level of 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, rcount + 1);
            chk("wrap_level", wr_level, 5'd3);
            chk("wrap_nofull", wfull, 1'b0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit en;
            int rc;
            en = ($urandom % 4) != 0;
            rc = rcount;
            if (rcount < wcount && ($urandom % 3) == 0) rc = rcount + 1;
            cycle(en, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
